// File: rtl/fixed_leaky_relu_arbiter_if.sv
// Handshake bundle for the shared leaky-ReLU lane: per-requester input streams
// in, one tagged activated stream out.
interface fixed_leaky_relu_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int PRECISION   = 8,
    parameter int PARALLELISM = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ*PARALLELISM*PRECISION-1:0] data_in;
    logic [NUM_REQ-1:0]                       data_in_valid;
    logic [NUM_REQ-1:0]                       data_in_ready;
    logic [PARALLELISM*PRECISION-1:0]         data_out_0;
    logic [ID_W-1:0]                          data_out_0_id;
    logic                                     data_out_0_last;
    logic                                     data_out_0_valid;
    logic                                     data_out_0_ready;

    modport slave (
        input  data_in, data_in_valid, data_out_0_ready,
        output data_in_ready, data_out_0, data_out_0_id, data_out_0_last, data_out_0_valid
    );

    modport master (
        output data_in, data_in_valid, data_out_0_ready,
        input  data_in_ready, data_out_0, data_out_0_id, data_out_0_last, data_out_0_valid
    );
endinterface

// File: rtl/fixed_leaky_relu_arbiter.sv
// Burst-granular round-robin arbiter feeding one registered leaky-ReLU lane.
// Optional counters enabled by FIXED_LEAKY_RELU_ARB_STATS_EN.
module fixed_leaky_relu_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int PRECISION   = 8,
    parameter int PARALLELISM = 4,
    parameter int BURST_BEATS = 8,
    parameter int SLOPE_EXP_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SLOPE_EXP_W-1:0] cfg_slope_exp,
    fixed_leaky_relu_arbiter_if.slave io
`ifdef FIXED_LEAKY_RELU_ARB_STATS_EN
    ,
    output logic [31:0]            stat_stall_cycles,
    output logic [31:0]            stat_bursts
`endif
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int PW    = PARALLELISM * PRECISION;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                   state, state_nxt;
    logic [ID_W-1:0]          grant, grant_nxt;
    logic [ID_W-1:0]          rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]         beat_cnt, beat_cnt_nxt;
    logic [SLOPE_EXP_W-1:0]   slope_exp;
    logic                     latch_cfg, accept, last_beat;
    logic [NUM_REQ-1:0]       ready;

    logic                     hit;
    logic [ID_W-1:0]          pick, cand;
    int unsigned              scan_idx;

    logic [PW-1:0]            out_data, act;
    logic [ID_W-1:0]          out_id;
    logic                     out_last, out_valid;
    logic signed [PRECISION-1:0] elem [PARALLELISM];

    // First valid requester at or above rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        hit      = 1'b0;
        pick     = '0;
        cand     = '0;
        scan_idx = 0;
        for (int unsigned i = 0; i < 32'(NUM_REQ); i++) begin
            scan_idx = 32'(rr_ptr) + i;
            if (scan_idx >= 32'(NUM_REQ))
                scan_idx = scan_idx - 32'(NUM_REQ);
            cand = ID_W'(scan_idx);
            if (!hit && io.data_in_valid[cand]) begin
                hit  = 1'b1;
                pick = cand;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        latch_cfg    = 1'b0;
        accept       = 1'b0;
        last_beat    = 1'b0;
        ready        = '0;
        case (state)
            IDLE: begin
                if (hit) begin
                    grant_nxt = pick;
                    latch_cfg = 1'b1;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                ready[grant] = ~out_valid | io.data_out_0_ready;
                accept       = io.data_in_valid[grant] & ready[grant];
                if (accept) begin
                    last_beat = (beat_cnt == CNT_W'(BURST_BEATS - 1));
                    if (last_beat) begin
                        beat_cnt_nxt = '0;
                        rr_ptr_nxt   = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
                        state_nxt    = IDLE;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Non-positive elements shift right arithmetically, i.e. floor toward -inf.
    always_comb begin
        act = '0;
        for (int unsigned e = 0; e < 32'(PARALLELISM); e++) begin
            elem[e] = io.data_in[(32'(grant) * 32'(PARALLELISM) + e) * 32'(PRECISION) +: PRECISION];
            act[e*PRECISION +: PRECISION] = elem[e][PRECISION-1] ? (elem[e] >>> slope_exp) : elem[e];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            slope_exp <= '0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
            if (latch_cfg)
                slope_exp <= cfg_slope_exp;
            if (accept) begin
                out_data  <= act;
                out_id    <= grant;
                out_last  <= last_beat;
                out_valid <= 1'b1;
            end else if (io.data_out_0_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign io.data_in_ready    = ready;
    assign io.data_out_0       = out_data;
    assign io.data_out_0_id    = out_id;
    assign io.data_out_0_last  = out_last;
    assign io.data_out_0_valid = out_valid;

`ifdef FIXED_LEAKY_RELU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_stall_cycles <= '0;
            stat_bursts       <= '0;
        end else begin
            if (out_valid && !io.data_out_0_ready && !(&stat_stall_cycles))
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            if (accept && last_beat && !(&stat_bursts))
                stat_bursts <= stat_bursts + 32'd1;
        end
    end
`endif
endmodule
